// File: rtl/spi_protocol_monitor.sv
// Passive SPI bus monitor and protocol checker.
// It oversamples sCLK, CS, MOSI and MISO on i_clk, rebuilds the MOSI and MISO
// words, reports frame boundaries and flags protocol errors. Error pulses also
// feed a saturating error counter.
//
// Ports:
//   i_clk              system clock, at least 4x the sCLK rate
//   i_rst              asynchronous active-low reset
//   sCLK/CS/MOSI/MISO  SPI bus taps (CS active-low, NUM_CS wide)
//   o_word_valid       one-cycle pulse when a word completes
//   o_mosi_word        last completed MOSI word, held
//   o_miso_word        last completed MISO word, held
//   o_cs_idx           index of the chip select of the current or last frame
//   o_frame_active     high while a frame is being tracked
//   o_frame_done       one-cycle pulse when the selected CS deasserts
//   o_frame_words      completed words in the last frame (saturating)
//   o_err_*            one-cycle protocol error pulses
//   o_err_count        saturating count of cycles with any error pulse
//
// state  | meaning
// IDLE   | no chip select low; waiting for a frame to start
// ACTIVE | exactly one chip select low; capturing bits
// FAULT  | several chip selects seen low; waits for all CS high
module spi_protocol_monitor #(
    parameter int  DATA_BYTE_WIDTH = 1,
    parameter int  NUM_CS          = 1,
    parameter int  CPOL            = 0,
    parameter int  CPHA            = 0,
    parameter int  MSB_FIRST       = 1,
    parameter int  SYNC_STAGES     = 2,
    parameter int  FRAME_CNT_W     = 8,
    parameter int  ERR_CNT_W       = 8,
    localparam int W               = DATA_BYTE_WIDTH * 8,
    localparam int CS_IDX_W        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   sCLK,
    input  logic [NUM_CS-1:0]      CS,
    input  logic                   MOSI,
    input  logic                   MISO,
    output logic                   o_word_valid,
    output logic [W-1:0]           o_mosi_word,
    output logic [W-1:0]           o_miso_word,
    output logic [CS_IDX_W-1:0]    o_cs_idx,
    output logic                   o_frame_active,
    output logic                   o_frame_done,
    output logic [FRAME_CNT_W-1:0] o_frame_words,
    output logic                   o_err_multi_cs,
    output logic                   o_err_partial_word,
    output logic                   o_err_sclk_idle,
    output logic                   o_err_sclk_no_cs,
    output logic [ERR_CNT_W-1:0]   o_err_count
);

    localparam int   BIT_CNT_W = $clog2(W + 1);
    localparam logic IDLE_LVL  = (CPOL != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FAULT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] miso_sync;
    logic [NUM_CS-1:0]      cs_sync [SYNC_STAGES];
    logic                   sclk_d;
    logic [W-1:0]           mosi_sh;
    logic [W-1:0]           miso_sh;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [FRAME_CNT_W-1:0] word_cnt;

    logic                   sclk_s, mosi_s, miso_s;
    logic [NUM_CS-1:0]      cs_s, cs_low;
    logic                   lead, trail, any_edge, sample_edge;
    logic                   one_low, multi_low, other_low, own_high;
    logic [CS_IDX_W-1:0]    low_idx;
    logic [W-1:0]           mosi_nxt, miso_nxt;
    logic                   word_done;
    logic [FRAME_CNT_W-1:0] word_cnt_upd;
    logic                   e_multi, e_partial, e_idle, e_nocs;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            mosi_sync <= '0;
            miso_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) cs_sync[i] <= '1;
            sclk_d    <= IDLE_LVL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], MISO};
            cs_sync[0] <= CS;
            for (int i = 1; i < SYNC_STAGES; i++) cs_sync[i] <= cs_sync[i-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign miso_s = miso_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign cs_low = ~cs_s;

    assign lead        = (sclk_d == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail       = (sclk_d != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign any_edge    = (sclk_d != sclk_s);
    assign sample_edge = (CPHA != 0) ? trail : lead;

    // x & (x-1) clears the lowest set bit: nonzero means two or more CS low
    assign multi_low = (cs_low & (cs_low - NUM_CS'(1))) != '0;
    assign one_low   = (cs_low != '0) && !multi_low;
    assign own_high  = cs_s[o_cs_idx];

    always_comb begin
        low_idx   = '0;
        other_low = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_low[i]) begin
                low_idx = CS_IDX_W'(i);
                if (CS_IDX_W'(i) != o_cs_idx) other_low = 1'b1;
            end
        end
    end

    assign mosi_nxt = (MSB_FIRST != 0) ? {mosi_sh[W-2:0], mosi_s} : {mosi_s, mosi_sh[W-1:1]};
    assign miso_nxt = (MSB_FIRST != 0) ? {miso_sh[W-2:0], miso_s} : {miso_s, miso_sh[W-1:1]};

    assign word_done    = sample_edge && (bit_cnt == BIT_CNT_W'(W - 1));
    assign word_cnt_upd = (word_done && (word_cnt != '1)) ? word_cnt + FRAME_CNT_W'(1) : word_cnt;

    // A sample edge coincident with CS rise is counted before the partial check
    assign e_nocs    = (state == ST_IDLE) && (cs_low == '0) && any_edge;
    assign e_idle    = (state == ST_IDLE) && one_low && (sclk_s != IDLE_LVL);
    assign e_multi   = ((state == ST_IDLE) && multi_low) || ((state == ST_ACTIVE) && other_low);
    assign e_partial = (state == ST_ACTIVE) && !other_low && own_high
                       && ((bit_cnt != '0) || sample_edge) && !word_done;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state              <= ST_IDLE;
            mosi_sh            <= '0;
            miso_sh            <= '0;
            bit_cnt            <= '0;
            word_cnt           <= '0;
            o_word_valid       <= 1'b0;
            o_mosi_word        <= '0;
            o_miso_word        <= '0;
            o_cs_idx           <= '0;
            o_frame_active     <= 1'b0;
            o_frame_done       <= 1'b0;
            o_frame_words      <= '0;
            o_err_multi_cs     <= 1'b0;
            o_err_partial_word <= 1'b0;
            o_err_sclk_idle    <= 1'b0;
            o_err_sclk_no_cs   <= 1'b0;
            o_err_count        <= '0;
        end else begin
            o_word_valid       <= 1'b0;
            o_frame_done       <= 1'b0;
            o_err_multi_cs     <= e_multi;
            o_err_partial_word <= e_partial;
            o_err_sclk_idle    <= e_idle;
            o_err_sclk_no_cs   <= e_nocs;
            if ((e_multi || e_partial || e_idle || e_nocs) && (o_err_count != '1))
                o_err_count <= o_err_count + ERR_CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (multi_low) begin
                        state <= ST_FAULT;
                    end else if (one_low) begin
                        state          <= ST_ACTIVE;
                        o_frame_active <= 1'b1;
                        o_cs_idx       <= low_idx;
                        bit_cnt        <= '0;
                        word_cnt       <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (other_low) begin
                        state          <= ST_FAULT;
                        o_frame_active <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            mosi_sh <= mosi_nxt;
                            miso_sh <= miso_nxt;
                            if (word_done) begin
                                o_mosi_word  <= mosi_nxt;
                                o_miso_word  <= miso_nxt;
                                o_word_valid <= 1'b1;
                                bit_cnt      <= '0;
                                word_cnt     <= word_cnt_upd;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end
                        if (own_high) begin
                            state          <= ST_IDLE;
                            o_frame_active <= 1'b0;
                            o_frame_done   <= 1'b1;
                            o_frame_words  <= word_cnt_upd;
                        end
                    end
                end
                ST_FAULT: begin
                    if (cs_low == '0) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_protocol_monitor.sv
// Bench for spi_protocol_monitor. Two instances:
//   A: mode 0, MSB first, two chip selects, 8-bit error counter
//   B: mode 3, LSB first, one chip select, 2-bit error counter
// Bus waveforms are generated from the SPI mode rules; the reference model
// expects every fully transmitted word back unchanged and counts the errors
// each scenario must raise.
module tb_spi_protocol_monitor;

    localparam int H = 4;   // i_clk cycles per sCLK half period

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       sclk_a, mosi_a, miso_a;
    logic [1:0] cs_a;
    logic       sclk_b, mosi_b, miso_b;
    logic [0:0] cs_b;

    logic       a_word_valid, a_frame_active, a_frame_done;
    logic [7:0] a_mosi_word, a_miso_word, a_frame_words, a_err_count;
    logic [0:0] a_cs_idx;
    logic       a_err_multi, a_err_partial, a_err_idle, a_err_nocs;

    logic       b_word_valid, b_frame_active, b_frame_done;
    logic [7:0] b_mosi_word, b_miso_word, b_frame_words;
    logic [1:0] b_err_count;
    logic [0:0] b_cs_idx;
    logic       b_err_multi, b_err_partial, b_err_idle, b_err_nocs;

    spi_protocol_monitor #(
        .DATA_BYTE_WIDTH(1), .NUM_CS(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1),
        .SYNC_STAGES(2), .FRAME_CNT_W(8), .ERR_CNT_W(8)
    ) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .sCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a),
        .o_word_valid(a_word_valid), .o_mosi_word(a_mosi_word), .o_miso_word(a_miso_word),
        .o_cs_idx(a_cs_idx), .o_frame_active(a_frame_active), .o_frame_done(a_frame_done),
        .o_frame_words(a_frame_words), .o_err_multi_cs(a_err_multi),
        .o_err_partial_word(a_err_partial), .o_err_sclk_idle(a_err_idle),
        .o_err_sclk_no_cs(a_err_nocs), .o_err_count(a_err_count)
    );

    spi_protocol_monitor #(
        .DATA_BYTE_WIDTH(1), .NUM_CS(1), .CPOL(1), .CPHA(1), .MSB_FIRST(0),
        .SYNC_STAGES(2), .FRAME_CNT_W(8), .ERR_CNT_W(2)
    ) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .sCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b),
        .o_word_valid(b_word_valid), .o_mosi_word(b_mosi_word), .o_miso_word(b_miso_word),
        .o_cs_idx(b_cs_idx), .o_frame_active(b_frame_active), .o_frame_done(b_frame_done),
        .o_frame_words(b_frame_words), .o_err_multi_cs(b_err_multi),
        .o_err_partial_word(b_err_partial), .o_err_sclk_idle(b_err_idle),
        .o_err_sclk_no_cs(b_err_nocs), .o_err_count(b_err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // observed activity, gathered by the monitor process below
    logic [15:0] got_q0[$], got_q1[$];
    int got_done[2], got_partial[2], got_multi[2], got_idle[2], got_nocs[2];

    // reference model state
    logic [15:0] exp_q0[$], exp_q1[$];
    int exp_done[2], exp_partial[2], exp_multi[2], exp_idle[2], exp_nocs[2];
    int exp_err[2], exp_fw[2], exp_idx[2], cur_words[2], cur_bits[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (a_word_valid)  got_q0.push_back({a_mosi_word, a_miso_word});
        if (a_frame_done)  got_done[0]++;
        if (a_err_partial) got_partial[0]++;
        if (a_err_multi)   got_multi[0]++;
        if (a_err_idle)    got_idle[0]++;
        if (a_err_nocs)    got_nocs[0]++;
        if (b_word_valid)  got_q1.push_back({b_mosi_word, b_miso_word});
        if (b_frame_done)  got_done[1]++;
        if (b_err_partial) got_partial[1]++;
        if (b_err_multi)   got_multi[1]++;
        if (b_err_idle)    got_idle[1]++;
        if (b_err_nocs)    got_nocs[1]++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic cpol_of(input int sel); return sel == 1; endfunction
    function automatic logic cpha_of(input int sel); return sel == 1; endfunction
    function automatic logic msb_of(input int sel);  return sel == 0; endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic drive_sclk(input int sel, input logic v);
        if (sel == 0) sclk_a = v; else sclk_b = v;
    endtask

    task automatic drive_cs(input int sel, input logic [1:0] v);
        if (sel == 0) cs_a = v; else cs_b = v[0];
    endtask

    task automatic drive_data(input int sel, input logic mo, input logic mi);
        if (sel == 0) begin mosi_a = mo; miso_a = mi; end
        else begin mosi_b = mo; miso_b = mi; end
    endtask

    // Puts the first n wire bits of a word on the bus in the instance's mode
    task automatic send_bits(input int sel, input logic [7:0] mo, input logic [7:0] mi, input int n);
        for (int j = 0; j < n; j++) begin
            int b;
            b = msb_of(sel) ? 7 - j : j;
            if (!cpha_of(sel)) drive_data(sel, mo[b], mi[b]);
            wait_clk(H);
            drive_sclk(sel, !cpol_of(sel));
            if (cpha_of(sel)) drive_data(sel, mo[b], mi[b]);
            wait_clk(H);
            drive_sclk(sel, cpol_of(sel));
        end
    endtask

    task automatic check_state(input int sel, input logic exp_active);
        logic [15:0] gq[$], eq[$];
        string p;
        int lim, act, fw, idx, ec;
        p = (sel == 0) ? "a" : "b";
        if (sel == 0) begin
            gq = got_q0; eq = exp_q0; got_q0.delete(); exp_q0.delete();
            act = a_frame_active; fw = a_frame_words; idx = a_cs_idx; ec = a_err_count; lim = 255;
        end else begin
            gq = got_q1; eq = exp_q1; got_q1.delete(); exp_q1.delete();
            act = b_frame_active; fw = b_frame_words; idx = b_cs_idx; ec = b_err_count; lim = 3;
        end
        check_val({p, ".n_words"}, gq.size(), eq.size());
        while (gq.size() > 0 && eq.size() > 0)
            check_val({p, ".word"}, gq.pop_front(), eq.pop_front());
        check_val({p, ".frame_done_cnt"}, got_done[sel], exp_done[sel]);
        check_val({p, ".frame_words"}, fw, exp_fw[sel]);
        check_val({p, ".cs_idx"}, idx, exp_idx[sel]);
        check_val({p, ".frame_active"}, act, exp_active);
        check_val({p, ".err_partial_cnt"}, got_partial[sel], exp_partial[sel]);
        check_val({p, ".err_multi_cnt"}, got_multi[sel], exp_multi[sel]);
        check_val({p, ".err_idle_cnt"}, got_idle[sel], exp_idle[sel]);
        check_val({p, ".err_nocs_cnt"}, got_nocs[sel], exp_nocs[sel]);
        check_val({p, ".err_count"}, ec, (exp_err[sel] > lim) ? lim : exp_err[sel]);
    endtask

    task automatic frame_begin(input int sel, input int idx);
        logic [1:0] v;
        v = 2'b11;
        v[idx] = 1'b0;
        drive_cs(sel, v);
        cur_words[sel] = 0;
        cur_bits[sel]  = 0;
        exp_idx[sel]   = idx;
        wait_clk(H);
        check_val((sel == 0) ? "a.active_start" : "b.active_start",
                  (sel == 0) ? a_frame_active : b_frame_active, 1);
    endtask

    task automatic send_word(input int sel, input logic [7:0] mo, input logic [7:0] mi);
        if (sel == 0) exp_q0.push_back({mo, mi}); else exp_q1.push_back({mo, mi});
        send_bits(sel, mo, mi, 8);
        cur_words[sel]++;
    endtask

    task automatic send_partial(input int sel, input int n);
        send_bits(sel, 8'($urandom), 8'($urandom), n);
        cur_bits[sel] += n;
    endtask

    task automatic frame_end(input int sel);
        wait_clk(H);
        drive_cs(sel, 2'b11);
        wait_clk(H + 4);
        exp_done[sel]++;
        exp_fw[sel] = cur_words[sel];
        if (cur_bits[sel] != 0) begin
            exp_partial[sel]++;
            exp_err[sel]++;
        end
        check_state(sel, 1'b0);
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            got_done[s] = 0; got_partial[s] = 0; got_multi[s] = 0; got_idle[s] = 0; got_nocs[s] = 0;
            exp_done[s] = 0; exp_partial[s] = 0; exp_multi[s] = 0; exp_idle[s] = 0; exp_nocs[s] = 0;
            exp_err[s] = 0; exp_fw[s] = 0; exp_idx[s] = 0; cur_words[s] = 0; cur_bits[s] = 0;
        end
        got_q0.delete(); got_q1.delete(); exp_q0.delete(); exp_q1.delete();
    endtask

    initial begin
        sclk_a = 1'b0; cs_a = 2'b11; mosi_a = 1'b0; miso_a = 1'b0;
        sclk_b = 1'b1; cs_b = 1'b1;  mosi_b = 1'b0; miso_b = 1'b0;
        clear_model();
        i_rst = 1'b0;
        wait_clk(3);
        check_val("rst.a_word_valid", a_word_valid, 0);
        check_val("rst.a_mosi_word", a_mosi_word, 0);
        check_val("rst.a_frame_active", a_frame_active, 0);
        check_val("rst.a_frame_words", a_frame_words, 0);
        check_val("rst.a_err_count", a_err_count, 0);
        check_val("rst.b_miso_word", b_miso_word, 0);
        check_val("rst.b_err_count", b_err_count, 0);
        i_rst = 1'b1;
        wait_clk(5);

        // mode 0 single word
        frame_begin(0, 0);
        send_word(0, 8'hA5, 8'h3C);
        frame_end(0);

        // 5 bits then CS high: partial word, no word captured
        frame_begin(0, 0);
        send_partial(0, 5);
        frame_end(0);

        // mode 3, LSB first, two words
        frame_begin(1, 0);
        send_word(1, 8'h12, 8'hF0);
        send_word(1, 8'h34, 8'h0F);
        frame_end(1);

        // second CS falls mid-frame
        frame_begin(0, 0);
        send_partial(0, 3);
        drive_cs(0, 2'b00);
        wait_clk(H + 2);
        exp_multi[0]++;
        exp_err[0]++;
        check_state(0, 1'b0);
        drive_cs(0, 2'b11);
        wait_clk(H + 2);
        frame_begin(0, 1);
        send_word(0, 8'h5A, 8'($urandom));
        frame_end(0);

        // sCLK toggling with no chip select
        for (int k = 0; k < 4; k++) begin
            drive_sclk(0, (k % 2) == 0);
            wait_clk(H);
        end
        exp_nocs[0] += 4;
        exp_err[0]  += 4;
        check_state(0, 1'b0);

        // CS falls while sCLK is away from its idle level
        drive_sclk(0, 1'b1);
        wait_clk(H);
        exp_nocs[0]++;
        exp_err[0]++;
        frame_begin(0, 0);
        exp_idle[0]++;
        exp_err[0]++;
        drive_sclk(0, 1'b0);
        wait_clk(H);
        send_word(0, 8'($urandom), 8'($urandom));
        frame_end(0);

        // five errors on the 2-bit counter: saturates at 3
        frame_begin(1, 0);
        send_partial(1, 3);
        frame_end(1);
        for (int k = 0; k < 4; k++) begin
            drive_sclk(1, (k % 2) == 1);
            wait_clk(H);
        end
        exp_nocs[1] += 4;
        exp_err[1]  += 4;
        check_state(1, 1'b0);

        // randomized frames on both instances
        for (int f = 0; f < 16; f++) begin
            int sel, idx, nw, extra;
            sel   = (f % 3 == 2) ? 1 : 0;
            idx   = (sel == 0) ? $urandom_range(0, 1) : 0;
            nw    = $urandom_range(0, 3);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            frame_begin(sel, idx);
            for (int w = 0; w < nw; w++) send_word(sel, 8'($urandom), 8'($urandom));
            if (extra != 0) send_partial(sel, extra);
            frame_end(sel);
        end

        // reset in the middle of a frame
        frame_begin(0, 0);
        send_partial(0, 4);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_val("midrst.a_frame_active", a_frame_active, 0);
        check_val("midrst.a_mosi_word", a_mosi_word, 0);
        check_val("midrst.a_frame_words", a_frame_words, 0);
        check_val("midrst.a_err_count", a_err_count, 0);
        check_val("midrst.a_cs_idx", a_cs_idx, 0);
        check_val("midrst.b_err_count", b_err_count, 0);
        drive_cs(0, 2'b11);
        drive_sclk(0, 1'b0);
        wait_clk(3);
        clear_model();
        i_rst = 1'b1;
        wait_clk(4);
        frame_begin(0, 0);
        send_word(0, 8'hC3, 8'($urandom));
        frame_end(0);
        check_state(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
